// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle for uart_tx_fifo.
// Ports: wr_data/wr_valid from producer, wr_ready from FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO and configurable frame format.
// Ports: sys_clk, sys_rst_n, wr (slave handshake), tx, busy,
// tx_done, fifo_level.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 24_000_000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    uart_tx_fifo_if.slave                 wr,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int BW       = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;

    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 tx_nxt;
    logic                 done_nxt;

    // Full is judged on registered level only, so a pop in the
    // same cycle never opens a slot early.
    assign wr.wr_ready = (fifo_level != LW'(FIFO_DEPTH));
    assign push        = wr.wr_valid & wr.wr_ready;

    assign bit_end   = (baud_cnt == BW'(BAUD_DIV - 1));
    assign last_data = bit_end && (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = bit_end && (bit_cnt == 4'(STOP_BITS - 1));

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (last_data) begin
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_nxt = par;
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (last_stop) begin
                    done_nxt = 1'b1;
                    // Chain straight into the next start bit.
                    if (fifo_level != '0) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // tx, tx_done and busy are registered together so they stay
    // cycle-aligned with each other, one cycle behind the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx      <= tx_nxt;
            tx_done <= done_nxt;
            busy    <= (state != IDLE);

            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end

            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (pop) begin
                shift <= mem[rd_ptr];
                par   <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
            end else if (state == DATA && bit_end) begin
                shift <= shift >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// Four DUT configurations share one clock and reset.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] wd = '0;
    logic [3:0] wv = '0;

    wire [3:0] tx_w;
    wire [3:0] busy_w;
    wire [3:0] done_w;
    wire [3:0] rdy;
    wire [2:0] lvl_a;
    wire [4:0] lvl_e;
    wire [4:0] lvl_o;
    wire [4:0] lvl_s;

    int checks = 0;
    int errors = 0;
    int dn_cnt = 0;

    int NB[4]   = '{8, 8, 8, 7};
    int PEN[4]  = '{0, 1, 1, 0};
    int PODD[4] = '{0, 0, 1, 0};

    logic [8:0] wq[$];
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    typedef struct {
        int         k;
        logic [8:0] d;
        int         len;
        int         par;
    } vec_t;
    vec_t tbl[8];

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_e ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_o ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if_s ();

    assign if_a.wr_data  = wd[7:0];
    assign if_e.wr_data  = wd[7:0];
    assign if_o.wr_data  = wd[7:0];
    assign if_s.wr_data  = wd[6:0];
    assign if_a.wr_valid = wv[0];
    assign if_e.wr_valid = wv[1];
    assign if_o.wr_valid = wv[2];
    assign if_s.wr_valid = wv[3];
    assign rdy = {if_s.wr_ready, if_o.wr_ready,
                  if_e.wr_ready, if_a.wr_ready};

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000),
        .FIFO_DEPTH(4)
    ) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr(if_a),
        .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]),
        .fifo_level(lvl_a)
    );

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000),
        .PARITY_EN(1), .PARITY_ODD(0)
    ) u_e (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr(if_e),
        .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]),
        .fifo_level(lvl_e)
    );

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000),
        .PARITY_EN(1), .PARITY_ODD(1)
    ) u_o (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr(if_o),
        .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]),
        .fifo_level(lvl_o)
    );

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000),
        .DATA_BITS(7), .STOP_BITS(2)
    ) u_s (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr(if_s),
        .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]),
        .fifo_level(lvl_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (done_w[0]) dn_cnt++;
    end

    // Mid-bit sampling receiver for the 8N1 instance.
    initial begin
        logic [7:0] d;
        d = '0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_w[0] === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    d[i] = tx_w[0];
                end
                repeat (10) @(negedge clk);
                if (tx_w[0]) rxq.push_back(d);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic model_bit(int k, logic [8:0] d, int j);
        logic p;
        p = (PODD[k] != 0);
        for (int i = 0; i < NB[k]; i++) p = p ^ d[i];
        if (j == 0) return 1'b0;
        if (j <= NB[k]) return d[j-1];
        if (PEN[k] != 0 && j == NB[k] + 1) return p;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_w[k] || !tx_w[k] || !rdy[k]) && n < 3000);
        check("idle_wait", n < 3000, 1);
    endtask

    task automatic send_check(input int k, input int n, input int len,
                              input int par);
        int f, c, btx, bdn, bbz;
        logic etx, edn, ebz;
        btx = 0; bdn = 0; bbz = 0;
        wait_idle(k);
        wd = wq[0];
        wv[k] = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc <= n * len + 2; cyc++) begin
            @(negedge clk);
            if (cyc + 1 < n) begin
                wd = wq[cyc+1];
            end else begin
                wv[k] = 1'b0;
                wd = 9'($urandom);
            end
            f = cyc - 2;
            if (f >= 0 && f < n * len) begin
                c = f % len;
                etx = model_bit(k, wq[f/len], c / 10);
                edn = (c == len - 1);
                ebz = 1'b1;
            end else begin
                etx = 1'b1; edn = 1'b0; ebz = 1'b0;
            end
            if (tx_w[k] !== etx) btx++;
            if (done_w[k] !== edn) bdn++;
            if (busy_w[k] !== ebz) bbz++;
            if (par >= 0 && f == (1 + NB[k]) * 10 + 5)
                check("parity_bit", tx_w[k], par);
            @(posedge clk);
        end
        check("tx_wave_bad_cycles", btx, 0);
        check("tx_done_bad_cycles", bdn, 0);
        check("busy_bad_cycles", bbz, 0);
    endtask

    initial begin
        int acc[6];
        int exp_acc[6];
        int i, cyc, bad, n;
        logic r, v;

        tbl[0] = '{0, 9'h000, 100, -1};
        tbl[1] = '{1, 9'h0A5, 110, 0};
        tbl[2] = '{2, 9'h0A5, 110, 1};
        tbl[3] = '{3, 9'h041, 100, -1};
        tbl[4] = '{1, 9'h000, 110, 0};
        tbl[5] = '{2, 9'h000, 110, 1};
        tbl[6] = '{0, 9'h080, 100, -1};
        tbl[7] = '{3, 9'h07F, 100, -1};
        exp_acc = '{0, 1, 2, 3, 4, 102};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx_w, 4'hF);
        check("rst_busy", busy_w, 4'h0);
        check("rst_done", done_w, 4'h0);
        check("rst_ready", rdy, 4'hF);
        check("rst_level", {lvl_a, lvl_e, lvl_o, lvl_s}, 0);
        rst_n = 1'b1;

        // single-frame vectors
        for (int t = 0; t < 8; t++) begin
            wq.delete();
            wq.push_back(tbl[t].d);
            send_check(tbl[t].k, 1, tbl[t].len, tbl[t].par);
        end

        // back-to-back frames
        wq = '{9'h055, 9'h0AA, 9'h0FF};
        send_check(0, 3, 100, -1);

        // FIFO fill and stall, depth 4
        wait_idle(0);
        rxq.delete();
        i = 0; cyc = 0;
        wd = 9'd1; wv[0] = 1'b1;
        while (i < 6 && cyc < 400) begin
            r = rdy[0];
            @(posedge clk);
            if (r) begin
                acc[i] = cyc;
                i++;
            end
            cyc++;
            @(negedge clk);
            if (cyc == 5) begin
                check("full_level", lvl_a, 4);
                check("full_ready", rdy[0], 0);
            end
            if (i < 6) wd = 9'(i + 1);
            else wv[0] = 1'b0;
        end
        wv[0] = 1'b0;
        check("stall_accepted", i, 6);
        for (int j = 0; j < 6; j++) check("accept_cycle", acc[j], exp_acc[j]);
        n = 0;
        while (rxq.size() < 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("stall_rx_count", rxq.size(), 6);
        bad = 0;
        for (int j = 0; j < 6; j++)
            if (j >= rxq.size() || rxq[j] != 8'(j + 1)) bad++;
        check("stall_rx_order", bad, 0);

        // randomized traffic vs queue model
        wait_idle(0);
        rxq.delete();
        expq.delete();
        dn_cnt = 0;
        bad = 0;
        for (int t = 0; t < 800; t++) begin
            r = rdy[0];
            if (r !== (lvl_a != 3'd4)) bad++;
            v = ($urandom_range(0, 3) == 0);
            wv[0] = v;
            wd = 9'($urandom);
            @(posedge clk);
            if (v && r) expq.push_back(wd[7:0]);
            @(negedge clk);
        end
        wv[0] = 1'b0;
        check("rand_ready_vs_level", bad, 0);
        n = 0;
        while ((lvl_a != 0 || busy_w[0]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rand_drain", n < 2000, 1);
        repeat (20) @(negedge clk);
        check("rand_rx_count", rxq.size(), expq.size());
        check("rand_done_count", dn_cnt, expq.size());
        bad = 0;
        for (int j = 0; j < expq.size(); j++)
            if (j >= rxq.size() || rxq[j] != expq[j]) bad++;
        check("rand_rx_data", bad, 0);

        // reset in the middle of a frame
        wait_idle(0);
        wd = 9'h000; wv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        wv[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_reset_tx", tx_w[0], 0);
        check("pre_reset_level", lvl_a, 1);
        rst_n = 1'b0;
        #1;
        check("reset_tx_async", tx_w[0], 1);
        check("reset_level", lvl_a, 0);
        check("reset_busy", busy_w[0], 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[0] || !tx_w[0]) bad++;
        end
        rst_n = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (done_w[0] || !tx_w[0] || busy_w[0]) bad++;
        end
        check("post_reset_idle", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
